// File: rtl/tlb_pkg.sv
// tlb_pkg: shared types, sizes, INVTLB op codes and match/select helpers
// for the fully-associative LoongArch TLB.
//   tlb_entry_t  - one stored TLB entry (both odd and even pages)
//   tlb_result_t - one search port's result
//   vppn_match   - page-size-aware VPPN comparator, used by search and INVTLB
//   page_result  - builds a hit result from the odd/even page of an entry
package tlb_pkg;

  localparam int TLBNUM   = 16;
  localparam int TLBIDLEN = 4;

  // INVTLB op codes; anything above INV_G1ORASID_VA changes no state.
  localparam logic [4:0] INV_ALL0        = 5'd0;
  localparam logic [4:0] INV_ALL1        = 5'd1;
  localparam logic [4:0] INV_G1          = 5'd2;
  localparam logic [4:0] INV_G0          = 5'd3;
  localparam logic [4:0] INV_G0_ASID     = 5'd4;
  localparam logic [4:0] INV_G0_ASID_VA  = 5'd5;
  localparam logic [4:0] INV_G1ORASID_VA = 5'd6;

  // 2 MB pages use ps = 21; every other value is treated as a 4 KB page.
  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_2M = 6'd21;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic [19:0] ppn0;
    logic [19:0] ppn1;
    logic [1:0]  plv0;
    logic [1:0]  plv1;
    logic [1:0]  mat0;
    logic [1:0]  mat1;
    logic        d0;
    logic        d1;
    logic        v0;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic                found;
    logic [TLBIDLEN-1:0] index;
    logic [19:0]         ppn;
    logic [5:0]          ps;
    logic [1:0]          plv;
    logic [1:0]          mat;
    logic                d;
    logic                v;
  } tlb_result_t;

  // A 2 MB entry covers a double page of 4 MB, so only VA[31:22] take part.
  function automatic logic vppn_match(input logic [18:0] ent_vppn,
                                      input logic [5:0]  ent_ps,
                                      input logic [18:0] va_vppn);
    logic m;
    if (ent_ps == PS_2M) begin
      m = (ent_vppn[18:9] == va_vppn[18:9]);
    end else begin
      m = (ent_vppn == va_vppn);
    end
    return m;
  endfunction

  // The odd/even page bit is VA[12] for 4 KB pages and VA[21] for 2 MB pages.
  function automatic tlb_result_t page_result(input tlb_entry_t          ent,
                                              input logic [TLBIDLEN-1:0] idx,
                                              input logic [18:0]         va_vppn,
                                              input logic                va_bit12);
    tlb_result_t res;
    logic        odd;
    odd       = (ent.ps == PS_2M) ? va_vppn[8] : va_bit12;
    res.found = 1'b1;
    res.index = idx;
    res.ps    = ent.ps;
    if (odd) begin
      res.ppn = ent.ppn1;
      res.plv = ent.plv1;
      res.mat = ent.mat1;
      res.d   = ent.d1;
      res.v   = ent.v1;
    end else begin
      res.ppn = ent.ppn0;
      res.plv = ent.plv0;
      res.mat = ent.mat0;
      res.d   = ent.d0;
      res.v   = ent.v0;
    end
    return res;
  endfunction

endpackage

// File: rtl/tlb_lookup.sv
// tlb_lookup: one combinational search port. Matches every entry against
// the VA/ASID and priority-encodes the lowest hitting index.
//   i_entries  - full entry array
//   i_vppn     - VA[31:13]
//   i_va_bit12 - VA[12]
//   i_asid     - current ASID
//   o_result   - hit flag plus selected page fields (all zero on a miss)
module tlb_lookup
  import tlb_pkg::*;
(
  input  tlb_entry_t [TLBNUM-1:0] i_entries,
  input  logic [18:0]             i_vppn,
  input  logic                    i_va_bit12,
  input  logic [9:0]              i_asid,
  output tlb_result_t             o_result
);

  logic [TLBNUM-1:0] w_hit;

  // Per-entry hit: valid, global-or-ASID match, page-size-aware VPPN match.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      w_hit[i] = i_entries[i].e &&
                 (i_entries[i].g || (i_entries[i].asid == i_asid)) &&
                 vppn_match(i_entries[i].vppn, i_entries[i].ps, i_vppn);
    end
  end

  // Priority encode: scanning high to low lets the lowest index overwrite.
  always_comb begin
    o_result = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      o_result = w_hit[i] ?
                 page_result(i_entries[i], TLBIDLEN'(i), i_vppn, i_va_bit12) :
                 o_result;
    end
  end

endmodule

// File: rtl/tlb.sv
// tlb: 16-entry fully-associative LoongArch TLB.
//   s0/s1/s2_*   - three independent combinational search ports
//                  (ifetch, LSU A / TLBSRCH, LSU B)
//   invtlb_*     - INVTLB request; clears e bits of matching entries
//   we/w_index/w_entry - TLBWR/TLBFILL entry write
//   r_index/r_entry    - combinational TLBRD read
// Writes and invalidations take effect at the rising edge; searches and
// reads in the same cycle see the pre-edge contents.
module tlb
  import tlb_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic [18:0]         s0_vppn,
  input  logic                s0_va_bit12,
  input  logic [9:0]          s0_asid,
  output tlb_result_t         s0_result,
  input  logic [18:0]         s1_vppn,
  input  logic                s1_va_bit12,
  input  logic [9:0]          s1_asid,
  output tlb_result_t         s1_result,
  input  logic [18:0]         s2_vppn,
  input  logic                s2_va_bit12,
  input  logic [9:0]          s2_asid,
  output tlb_result_t         s2_result,
  input  logic                invtlb_valid,
  input  logic [4:0]          invtlb_op,
  input  logic [9:0]          invtlb_asid,
  input  logic [31:0]         invtlb_va,
  input  logic                we,
  input  logic [TLBIDLEN-1:0] w_index,
  input  tlb_entry_t          w_entry,
  input  logic [TLBIDLEN-1:0] r_index,
  output tlb_entry_t          r_entry
);

  tlb_entry_t [TLBNUM-1:0] r_tlb;
  logic [TLBNUM-1:0]       w_inv_va;
  logic [TLBNUM-1:0]       w_inv_asid;
  logic [TLBNUM-1:0]       w_inv_hit;

  tlb_lookup u_lookup0 (
    .i_entries  (r_tlb),
    .i_vppn     (s0_vppn),
    .i_va_bit12 (s0_va_bit12),
    .i_asid     (s0_asid),
    .o_result   (s0_result)
  );

  tlb_lookup u_lookup1 (
    .i_entries  (r_tlb),
    .i_vppn     (s1_vppn),
    .i_va_bit12 (s1_va_bit12),
    .i_asid     (s1_asid),
    .o_result   (s1_result)
  );

  tlb_lookup u_lookup2 (
    .i_entries  (r_tlb),
    .i_vppn     (s2_vppn),
    .i_va_bit12 (s2_va_bit12),
    .i_asid     (s2_asid),
    .o_result   (s2_result)
  );

  // INVTLB operand matches per entry, using the same VPPN comparator as search.
  always_comb begin
    w_inv_va   = '0;
    w_inv_asid = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      w_inv_va[i]   = vppn_match(r_tlb[i].vppn, r_tlb[i].ps, invtlb_va[31:13]);
      w_inv_asid[i] = (r_tlb[i].asid == invtlb_asid);
    end
  end

  // Op-code decode into the per-entry invalidate vector.
  always_comb begin
    w_inv_hit = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      case (invtlb_op)
        INV_ALL0, INV_ALL1: w_inv_hit[i] = 1'b1;
        INV_G1:             w_inv_hit[i] = r_tlb[i].g;
        INV_G0:             w_inv_hit[i] = !r_tlb[i].g;
        INV_G0_ASID:        w_inv_hit[i] = !r_tlb[i].g && w_inv_asid[i];
        INV_G0_ASID_VA:     w_inv_hit[i] = !r_tlb[i].g && w_inv_asid[i] && w_inv_va[i];
        INV_G1ORASID_VA:    w_inv_hit[i] = (r_tlb[i].g || w_inv_asid[i]) && w_inv_va[i];
        default:            w_inv_hit[i] = 1'b0;
      endcase
    end
  end

  // Entry storage: a write to an index takes priority over invalidating it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tlb <= '0;
    end else begin
      for (int i = 0; i < TLBNUM; i++) begin
        if (we && (w_index == TLBIDLEN'(i))) begin
          r_tlb[i] <= w_entry;
        end else if (invtlb_valid && w_inv_hit[i]) begin
          r_tlb[i].e <= 1'b0;
        end else begin
          r_tlb[i] <= r_tlb[i];
        end
      end
    end
  end

  // TLBRD read port.
  assign r_entry = r_tlb[r_index];

endmodule

// File: tb/tb_tlb.sv
module tb_tlb;
  import tlb_pkg::*;

  logic                clk;
  logic                resetn;
  logic [18:0]         s0_vppn, s1_vppn, s2_vppn;
  logic                s0_va_bit12, s1_va_bit12, s2_va_bit12;
  logic [9:0]          s0_asid, s1_asid, s2_asid;
  tlb_result_t         s0_result, s1_result, s2_result;
  logic                invtlb_valid;
  logic [4:0]          invtlb_op;
  logic [9:0]          invtlb_asid;
  logic [31:0]         invtlb_va;
  logic                we;
  logic [TLBIDLEN-1:0] w_index;
  tlb_entry_t          w_entry;
  logic [TLBIDLEN-1:0] r_index;
  tlb_entry_t          r_entry;

  int n_checks;
  int n_pass;

  tlb_entry_t ent3, ent4, ent7;

  tlb dut (
    .clk(clk), .resetn(resetn),
    .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid), .s0_result(s0_result),
    .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid), .s1_result(s1_result),
    .s2_vppn(s2_vppn), .s2_va_bit12(s2_va_bit12), .s2_asid(s2_asid), .s2_result(s2_result),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
    .invtlb_va(invtlb_va),
    .we(we), .w_index(w_index), .w_entry(w_entry),
    .r_index(r_index), .r_entry(r_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input logic [TLBIDLEN-1:0] idx, input tlb_entry_t ent);
    @(negedge clk);
    we      = 1'b1;
    w_index = idx;
    w_entry = ent;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic do_inv(input logic [4:0] op, input logic [9:0] asid, input logic [31:0] va);
    @(negedge clk);
    invtlb_valid = 1'b1;
    invtlb_op    = op;
    invtlb_asid  = asid;
    invtlb_va    = va;
    @(posedge clk);
    #1;
    invtlb_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    resetn = 1'b0;
    s0_vppn = 19'h00010; s0_va_bit12 = 1'b0; s0_asid = 10'd1;
    s1_vppn = 19'h00010; s1_va_bit12 = 1'b1; s1_asid = 10'd1;
    s2_vppn = 19'h400FF; s2_va_bit12 = 1'b0; s2_asid = 10'd9;
    invtlb_valid = 1'b0; invtlb_op = 5'd0; invtlb_asid = 10'd0; invtlb_va = 32'd0;
    we = 1'b0; w_index = 4'd0; w_entry = '0; r_index = 4'd5;

    ent3 = '0;
    ent3.e = 1'b1; ent3.vppn = 19'h00010; ent3.ps = 6'd12; ent3.g = 1'b0; ent3.asid = 10'd1;
    ent3.ppn0 = 20'h0A000; ent3.v0 = 1'b1;
    ent3.ppn1 = 20'h0B000; ent3.v1 = 1'b1; ent3.d1 = 1'b1; ent3.mat1 = 2'd1;

    ent7 = '0;
    ent7.e = 1'b1; ent7.vppn = 19'h40000; ent7.ps = 6'd21; ent7.g = 1'b1; ent7.asid = 10'd5;
    ent7.ppn0 = 20'h11111; ent7.v0 = 1'b1;
    ent7.ppn1 = 20'h22222; ent7.v1 = 1'b1; ent7.plv1 = 2'd3;

    ent4 = ent3;
    ent4.vppn = 19'h00020;

    // Reset state
    #3;
    check("rst_s0_found", 32'(s0_result.found), 32'd0);
    check("rst_s0_index", 32'(s0_result.index), 32'd0);
    check("rst_rentry_lo", r_entry[31:0], 32'd0);
    check("rst_rentry_hi", 32'(r_entry[88:32]), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Write entry 3; same-cycle search must still miss
    @(negedge clk);
    we = 1'b1; w_index = 4'd3; w_entry = ent3;
    #1;
    check("wr_same_cycle", 32'(s1_result.found), 32'd0);
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    check("e3_found", 32'(s1_result.found), 32'd1);
    check("e3_index", 32'(s1_result.index), 32'd3);
    check("e3_ppn_odd", 32'(s1_result.ppn), 32'h0B000);
    check("e3_d_odd", 32'(s1_result.d), 32'd1);
    check("e3_mat_odd", 32'(s1_result.mat), 32'd1);
    check("e3_ps", 32'(s1_result.ps), 32'd12);
    check("e3_ppn_even", 32'(s0_result.ppn), 32'h0A000);
    check("e3_d_even", 32'(s0_result.d), 32'd0);
    s1_asid = 10'd2;
    #1;
    check("e3_asid_miss", 32'(s1_result.found), 32'd0);
    check("e3_miss_ppn", 32'(s1_result.ppn), 32'd0);
    s1_asid = 10'd1;
    s0_vppn = 19'h00011;
    #1;
    check("e3_vppn_miss", 32'(s0_result.found), 32'd0);
    s0_vppn = 19'h00010;
    r_index = 4'd3;
    #1;
    check("rd3_ppn1", 32'(r_entry.ppn1), 32'h0B000);
    check("rd3_vppn", 32'(r_entry.vppn), 32'h00010);

    // 2 MB global entry 7
    write_entry(4'd7, ent7);
    #1;
    check("e7_found", 32'(s2_result.found), 32'd1);
    check("e7_index", 32'(s2_result.index), 32'd7);
    check("e7_ppn_even", 32'(s2_result.ppn), 32'h11111);
    check("e7_ps", 32'(s2_result.ps), 32'd21);
    s2_vppn = 19'h401FF;
    #1;
    check("e7_ppn_odd", 32'(s2_result.ppn), 32'h22222);
    check("e7_plv_odd", 32'(s2_result.plv), 32'd3);
    s2_vppn = 19'h40200;
    #1;
    check("e7_miss", 32'(s2_result.found), 32'd0);
    s2_vppn = 19'h400FF;

    // Duplicate of entry 3 at index 9: lowest index wins
    write_entry(4'd9, ent3);
    #1;
    check("multi_hit_idx", 32'(s1_result.index), 32'd3);

    // INVTLB op 4, asid 1: kills 3 and 9, keeps global 7
    do_inv(INV_G0_ASID, 10'd1, 32'd0);
    #1;
    check("op4_e3_miss", 32'(s1_result.found), 32'd0);
    check("op4_e7_hit", 32'(s2_result.found), 32'd1);

    // op 7: no change
    do_inv(5'd7, 10'd0, 32'd0);
    #1;
    check("op7_e7_hit", 32'(s2_result.found), 32'd1);

    // op 2: globals go, other fields retained
    do_inv(INV_G1, 10'd0, 32'd0);
    #1;
    check("op2_e7_miss", 32'(s2_result.found), 32'd0);
    r_index = 4'd7;
    #1;
    check("op2_rd7_e", 32'(r_entry.e), 32'd0);
    check("op2_rd7_ppn0", 32'(r_entry.ppn0), 32'h11111);

    // op 5: only entry 3 matches VA; entry 4 survives
    write_entry(4'd3, ent3);
    write_entry(4'd4, ent4);
    do_inv(INV_G0_ASID_VA, 10'd1, {19'h00010, 13'd0});
    #1;
    check("op5_e3_miss", 32'(s0_result.found), 32'd0);
    s0_vppn = 19'h00020;
    #1;
    check("op5_e4_hit", 32'(s0_result.index), 32'd4);
    check("op5_e4_found", 32'(s0_result.found), 32'd1);

    // op 6 with foreign asid on non-global entry: no effect
    do_inv(INV_G1ORASID_VA, 10'd2, {19'h00020, 13'd0});
    #1;
    check("op6_e4_kept", 32'(s0_result.found), 32'd1);

    // Simultaneous write to 3 and op 0: only entry 3 survives
    write_entry(4'd7, ent7);
    @(negedge clk);
    we = 1'b1; w_index = 4'd3; w_entry = ent3;
    invtlb_valid = 1'b1; invtlb_op = INV_ALL0;
    @(posedge clk);
    #1;
    we = 1'b0; invtlb_valid = 1'b0;
    #1;
    check("wrinv_e3_hit", 32'(s1_result.found), 32'd1);
    check("wrinv_e7_miss", 32'(s2_result.found), 32'd0);
    check("wrinv_e4_miss", 32'(s0_result.found), 32'd0);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_s1_miss", 32'(s1_result.found), 32'd0);
    r_index = 4'd3;
    #1;
    check("arst_rd3_lo", r_entry[31:0], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
